parking_management_system: RTL and testbench

Occupancy controller for a two-class car park with university-reserved spaces and general (non-university) spaces. It counts parked cars per class and derives the remaining free spaces per class. The split between the two classes follows an internal time-of-day schedule driven by a cycle-counted clock. It sits behind the gate sensors and feeds the entrance displays and admission logic.

---
 rtl/parking_management_system.sv | 107 ++++++++++
 tb/tb_parking_management_system.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parking_management_system.sv
// Two-class car park occupancy controller.
// Tracks uni/general counts and a cycle-counted time-of-day schedule.
module parking_management_system #(
  parameter int TOTAL_SPACES    = 700,
  parameter int BASE_FREE       = 200,
  parameter int STEP_FREE       = 50,
  parameter int EVENING_FREE    = 500,
  parameter int START_HOUR      = 8,
  parameter int CYCLES_PER_HOUR = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_entered,
  input  logic       is_uni_car_entered,
  input  logic       car_exited,
  input  logic       is_uni_car_exited,
  output logic [9:0] uni_parked_car,
  output logic [9:0] parked_car,
  output logic [9:0] uni_vacated_space,
  output logic [9:0] vacated_space,
  output logic       uni_is_vacated_space,
  output logic       is_vacated_space
);

  localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
  localparam logic [CW-1:0] LP_CYC_LAST = CW'(CYCLES_PER_HOUR - 1);
  localparam logic [4:0] LP_START = 5'(START_HOUR);
  localparam logic [9:0] LP_TOTAL = 10'(TOTAL_SPACES);
  localparam logic [9:0] LP_CAP0  = 10'(BASE_FREE);
  localparam logic [9:0] LP_CAP1  = 10'(BASE_FREE + STEP_FREE);
  localparam logic [9:0] LP_CAP2  = 10'(BASE_FREE + 2 * STEP_FREE);
  localparam logic [9:0] LP_CAP3  = 10'(BASE_FREE + 3 * STEP_FREE);
  localparam logic [9:0] LP_CAPE  = 10'(EVENING_FREE);

  logic [CW-1:0] r_cycle;
  logic [4:0]    r_hour;
  logic [9:0]    r_uni;
  logic [9:0]    r_gen;

  logic [9:0] w_gen_cap;
  logic [9:0] w_uni_cap;
  logic [9:0] w_uni_vac;
  logic [9:0] w_gen_vac;
  logic       w_uni_inc;
  logic       w_uni_dec;
  logic       w_gen_inc;
  logic       w_gen_dec;

  // General capacity from the hour-of-day schedule
  always_comb begin
    w_gen_cap = LP_CAPE;
    if (r_hour < 5'd13)       w_gen_cap = LP_CAP0;
    else if (r_hour == 5'd13) w_gen_cap = LP_CAP1;
    else if (r_hour == 5'd14) w_gen_cap = LP_CAP2;
    else if (r_hour == 5'd15) w_gen_cap = LP_CAP3;
  end

  assign w_uni_cap = LP_TOTAL - w_gen_cap;

  // Free space per class, clamped at zero when capacity shrinks under the count
  always_comb begin
    w_uni_vac = (w_uni_cap > r_uni) ? (w_uni_cap - r_uni) : 10'd0;
    w_gen_vac = (w_gen_cap > r_gen) ? (w_gen_cap - r_gen) : 10'd0;
  end

  // Admission: a same-class exit in this cycle makes room for the entry
  always_comb begin
    w_uni_dec = car_exited & is_uni_car_exited & (r_uni != 10'd0);
    w_gen_dec = car_exited & ~is_uni_car_exited & (r_gen != 10'd0);
    w_uni_inc = car_entered & is_uni_car_entered &
                ((w_uni_vac != 10'd0) | w_uni_dec);
    w_gen_inc = car_entered & ~is_uni_car_entered &
                ((w_gen_vac != 10'd0) | w_gen_dec);
  end

  // Time of day: cycle counter wraps into a saturating hour register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle <= '0;
      r_hour  <= LP_START;
    end else if (r_cycle == LP_CYC_LAST) begin
      r_cycle <= '0;
      if (r_hour != 5'd23) r_hour <= r_hour + 5'd1;
    end else begin
      r_cycle <= r_cycle + CW'(1);
    end
  end

  // Occupancy counters per class
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uni <= '0;
      r_gen <= '0;
    end else begin
      r_uni <= r_uni + {9'd0, w_uni_inc} - {9'd0, w_uni_dec};
      r_gen <= r_gen + {9'd0, w_gen_inc} - {9'd0, w_gen_dec};
    end
  end

  assign uni_parked_car       = r_uni;
  assign parked_car           = r_gen;
  assign uni_vacated_space    = w_uni_vac;
  assign vacated_space        = w_gen_vac;
  assign uni_is_vacated_space = (w_uni_vac != 10'd0);
  assign is_vacated_space     = (w_gen_vac != 10'd0);

endmodule

// File: tb/tb_parking_management_system.sv
// Directed testbench for parking_management_system.
// Uses a shortened hour so schedule changes fit in a short run.
module tb_parking_management_system;

  localparam int CPH = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_entered = 1'b0;
  logic       is_uni_car_entered = 1'b0;
  logic       car_exited = 1'b0;
  logic       is_uni_car_exited = 1'b0;
  logic [9:0] uni_parked_car;
  logic [9:0] parked_car;
  logic [9:0] uni_vacated_space;
  logic [9:0] vacated_space;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;

  int checks = 0;
  int errors = 0;

  parking_management_system #(
    .CYCLES_PER_HOUR(CPH)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .uni_parked_car      (uni_parked_car),
    .parked_car          (parked_car),
    .uni_vacated_space   (uni_vacated_space),
    .vacated_space       (vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       e;
    logic       eu;
    logic       x;
    logic       xu;
    logic [9:0] uni;
    logic [9:0] gen;
    logic [9:0] uvac;
    logic [9:0] vac;
    logic       uf;
    logic       f;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eu, input int eg,
                         input int euv, input int ev,
                         input int euf, input int ef);
    chk({tag, " uni_parked"}, int'(uni_parked_car), eu);
    chk({tag, " parked"}, int'(parked_car), eg);
    chk({tag, " uni_vac"}, int'(uni_vacated_space), euv);
    chk({tag, " vac"}, int'(vacated_space), ev);
    chk({tag, " uni_flag"}, int'(uni_is_vacated_space), euf);
    chk({tag, " flag"}, int'(is_vacated_space), ef);
  endtask

  // One clock edge with the given strobes; called at a falling edge
  task automatic step(input logic e, input logic eu,
                      input logic x, input logic xu);
    car_entered        = e;
    is_uni_car_entered = eu;
    car_exited         = x;
    is_uni_car_exited  = xu;
    @(negedge clk);
    car_entered        = 1'b0;
    is_uni_car_entered = 1'b0;
    car_exited         = 1'b0;
    is_uni_car_exited  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 10'd0, 10'd499, 10'd200, 1'b1, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd0, 10'd498, 10'd200, 1'b1, 1'b1};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd2, 10'd1, 10'd498, 10'd199, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd2, 10'd0, 10'd498, 10'd200, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd1, 10'd0, 10'd499, 10'd200, 1'b1, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd1, 10'd1, 10'd499, 10'd199, 1'b1, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd2, 10'd500, 10'd198, 1'b1, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 10'd1, 10'd499, 10'd199, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd1, 10'd1, 10'd499, 10'd199, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd1, 10'd500, 10'd199, 1'b1, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd1, 10'd500, 10'd199, 1'b1, 1'b1};
    tv[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 10'd1, 10'd499, 10'd199, 1'b1, 1'b1};

    // Reset state
    do_reset();
    chk_all("reset", 0, 0, 500, 200, 1, 1);

    // Basic table at hour 8
    for (int i = 0; i < 12; i++) begin
      step(tv[i].e, tv[i].eu, tv[i].x, tv[i].xu);
      chk_all($sformatf("vec%0d", i), int'(tv[i].uni), int'(tv[i].gen),
              int'(tv[i].uvac), int'(tv[i].vac),
              int'(tv[i].uf), int'(tv[i].f));
    end

    // 12 edges so far; 12000 more puts the clock in hour 14
    idle(12000);
    chk_all("h14", 1, 1, 399, 299, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("h14 entry", 1, 2, 399, 298, 1, 1);

    // Fill general at hour 8
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("gen full", 0, 200, 500, 0, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("gen refused", 0, 200, 500, 0, 1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("gen swap full", 0, 200, 500, 0, 1, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("uni no overflow", 1, 200, 499, 0, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("gen exit", 1, 199, 499, 1, 1, 1);

    // Capacity switches exactly on the 10000th edge (hour 13)
    do_reset();
    idle(9999);
    chk_all("pre 13", 0, 0, 500, 200, 1, 1);
    idle(1);
    chk_all("at 13", 0, 0, 450, 250, 1, 1);

    // 450 uni cars, then evening shrink
    do_reset();
    for (int i = 0; i < 450; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("uni 450", 450, 0, 50, 200, 1, 1);
    idle(16000);
    chk_all("h16", 450, 0, 0, 500, 0, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("h16 uni refused", 450, 0, 0, 500, 0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("gen empty exit", 450, 0, 0, 500, 0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("uni exit shrink", 449, 0, 0, 500, 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("h16 gen entry", 449, 1, 0, 499, 0, 1);

    // Asynchronous reset between edges, with strobes held high
    #2;
    car_entered        = 1'b1;
    is_uni_car_entered = 1'b0;
    reset              = 1'b1;
    #1;
    chk_all("async reset", 0, 0, 500, 200, 1, 1);
    @(posedge clk);
    #1;
    chk_all("reset hold", 0, 0, 500, 200, 1, 1);
    @(negedge clk);
    car_entered = 1'b0;
    reset       = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("post reset", 0, 1, 500, 199, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
